// File: rtl/am2904_status_shift.sv
// Am2904-style status/shift companion: micro and machine status registers,
// condition-test output, ALU carry-in select and RAM/Q shift linkage.
module am2904_status_shift (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] I,
    input  logic        nCEm,
    input  logic        nCEu,
    input  logic        nOEy,
    input  logic        Ic,
    input  logic        Iovr,
    input  logic        In,
    input  logic        Iz,
    input  logic        nEz,
    input  logic        nEc,
    input  logic        nEn,
    input  logic        nEovr,
    input  logic        Yz,
    input  logic        Yc,
    input  logic        Yn,
    input  logic        Yovr,
    output wire         oYz,
    output wire         oYc,
    output wire         oYn,
    output wire         oYovr,
    input  logic        nOEct,
    output wire         CT,
    input  logic        Cx,
    output logic        Co,
    input  logic        nSE,
    input  logic        SIO0,
    input  logic        SIOn,
    input  logic        QIO0,
    input  logic        QIOn,
    output wire         oSIO0,
    output wire         oSIOn,
    output wire         oQIO0,
    output wire         oQIOn
);

    localparam int unsigned FlagW = 4;
    localparam int unsigned OpW   = 6;

    // Flag vectors are ordered {Z, C, N, OVR}
    logic [FlagW-1:0] uSr;
    logic [FlagW-1:0] mSr;
    logic [FlagW-1:0] uNext;
    logic [FlagW-1:0] mLoad;
    logic [FlagW-1:0] mNext;
    logic [FlagW-1:0] mEn;
    logic [FlagW-1:0] iFlags;
    logic [FlagW-1:0] yFlags;
    logic [OpW-1:0]   op;
    logic             cond;
    logic             ctVal;
    logic             ramFill;
    logic             qFill;
    logic             leftShift;

    assign op        = I[5:0];
    assign iFlags    = {Iz, Ic, In, Iovr};
    assign mEn       = ~{nEz, nEc, nEn, nEovr};
    assign leftShift = I[10];

    // Next micro status value
    always_comb begin
        uNext = iFlags;
        case (op)
            6'o00, 6'o02:                 uNext = mSr;
            6'o01:                        uNext = {FlagW{1'b1}};
            6'o03:                        uNext = {FlagW{1'b0}};
            6'o06, 6'o07:                 uNext = {Iz, Ic, In, uSr[0] | Iovr};
            6'o10, 6'o11, 6'o14, 6'o15:   uNext = {Iz, ~Ic, In, Iovr};
            default:                      uNext = iFlags;
        endcase
    end

    // Next machine status value, merged bitwise through the per-bit enables
    always_comb begin
        mLoad = iFlags;
        case (op)
            6'o00, 6'o02:                 mLoad = uSr;
            6'o01:                        mLoad = {FlagW{1'b1}};
            6'o03:                        mLoad = {FlagW{1'b0}};
            6'o04, 6'o05:                 mLoad = {Yz, Yc, Yn, Yovr};
            6'o06, 6'o07:                 mLoad = {mSr[3], ~mSr[2], mSr[1:0]};
            6'o10, 6'o11, 6'o14, 6'o15:   mLoad = {Iz, ~Ic, In, Iovr};
            default:                      mLoad = iFlags;
        endcase
        mNext = (mLoad & mEn) | (mSr & ~mEn);
    end

    // Both registers sample pre-edge values, so op 02 exchanges atomically
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uSr <= '0;
            mSr <= '0;
        end else begin
            if (!nCEu) uSr <= uNext;
            if (!nCEm) mSr <= mNext;
        end
    end

    always_comb begin
        yFlags = uSr;
        if (I[5]) yFlags = I[4] ? iFlags : mSr;
    end

    // Condition test on the selected {Z,C,N,OVR}, polarity flipped by I0
    always_comb begin
        cond = 1'b0;
        case (I[3:1])
            3'd0:    cond = (yFlags[1] ^ yFlags[0]) | yFlags[3];
            3'd1:    cond = yFlags[1] ^ yFlags[0];
            3'd2:    cond = yFlags[3];
            3'd3:    cond = yFlags[0];
            3'd4:    cond = yFlags[2] | yFlags[3];
            3'd5:    cond = yFlags[2];
            3'd6:    cond = ~yFlags[2] | yFlags[3];
            default: cond = yFlags[1];
        endcase
        ctVal = cond ^ I[0];
    end

    always_comb begin
        Co = 1'b0;
        case (I[12:11])
            2'b00:   Co = 1'b0;
            2'b01:   Co = 1'b1;
            2'b10:   Co = Cx;
            default: Co = I[5] ? mSr[2] : uSr[2];
        endcase
    end

    // Fill bits enter from the far end of the shifter for rotates
    always_comb begin
        ramFill = 1'b0;
        qFill   = 1'b0;
        case (I[9:8])
            2'b00:   ramFill = 1'b0;
            2'b01:   ramFill = 1'b1;
            2'b10:   ramFill = leftShift ? SIOn : SIO0;
            default: ramFill = leftShift ? QIOn : QIO0;
        endcase
        case (I[7:6])
            2'b00:   qFill = 1'b0;
            2'b01:   qFill = 1'b1;
            2'b10:   qFill = leftShift ? QIOn : QIO0;
            default: qFill = leftShift ? SIOn : SIO0;
        endcase
    end

    assign oYz   = nOEy ? 1'bz : yFlags[3];
    assign oYc   = nOEy ? 1'bz : yFlags[2];
    assign oYn   = nOEy ? 1'bz : yFlags[1];
    assign oYovr = nOEy ? 1'bz : yFlags[0];
    assign CT    = nOEct ? 1'bz : ctVal;

    assign oSIOn = (nSE || leftShift)  ? 1'bz : ramFill;
    assign oQIOn = (nSE || leftShift)  ? 1'bz : qFill;
    assign oSIO0 = (nSE || !leftShift) ? 1'bz : ramFill;
    assign oQIO0 = (nSE || !leftShift) ? 1'bz : qFill;

endmodule

// File: tb/tb_am2904_status_shift.sv
// Directed bench for am2904_status_shift: register-op sequences plus a
// vector table for condition test, carry select and shift linkage.
module tb_am2904_status_shift;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] I;
    logic        nCEm, nCEu, nOEy, nOEct;
    logic        Ic, Iovr, In, Iz;
    logic        nEz, nEc, nEn, nEovr;
    logic        Yz, Yc, Yn, Yovr;
    logic        Cx, nSE, SIO0, SIOn, QIO0, QIOn;
    wire         oYz, oYc, oYn, oYovr, CT, oSIO0, oSIOn, oQIO0, oQIOn;
    logic        Co;

    int total = 0;
    int bad   = 0;

    am2904_status_shift dut (
        .clk(clk), .reset(reset), .I(I), .nCEm(nCEm), .nCEu(nCEu), .nOEy(nOEy),
        .Ic(Ic), .Iovr(Iovr), .In(In), .Iz(Iz),
        .nEz(nEz), .nEc(nEc), .nEn(nEn), .nEovr(nEovr),
        .Yz(Yz), .Yc(Yc), .Yn(Yn), .Yovr(Yovr),
        .oYz(oYz), .oYc(oYc), .oYn(oYn), .oYovr(oYovr),
        .nOEct(nOEct), .CT(CT), .Cx(Cx), .Co(Co),
        .nSE(nSE), .SIO0(SIO0), .SIOn(SIOn), .QIO0(QIO0), .QIOn(QIOn),
        .oSIO0(oSIO0), .oSIOn(oSIOn), .oQIO0(oQIO0), .oQIOn(oQIOn)
    );

    always #5 clk = ~clk;

    // Pin encoding for shift checks: 0, 1, or 2 meaning high-Z
    localparam logic [1:0] Z = 2'd2;

    typedef struct {
        logic [12:0] i;
        logic [3:0]  fl;     // {Iz,Ic,In,Iovr}
        logic        cx;
        logic        nse;
        logic [3:0]  pins;   // {SIO0,SIOn,QIO0,QIOn}
        logic [3:0]  expY;
        logic        expCt;
        logic        expCo;
        logic [7:0]  expSh;  // {oSIO0,oSIOn,oQIO0,oQIOn}
    } vec_t;

    function automatic logic [1:0] enc(input bit isZ, input logic v);
        return isZ ? Z : {1'b0, v};
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setFlags(input logic [3:0] f);
        {Iz, Ic, In, Iovr} = f;
    endtask

    function automatic logic [7:0] yNow();
        return {4'd0, oYz, oYc, oYn, oYovr};
    endfunction

    vec_t vecs[10];
    logic [7:0] shAct;

    initial begin
        reset = 1'b1; I = '0; nCEm = 1'b1; nCEu = 1'b1; nOEy = 1'b0; nOEct = 1'b0;
        setFlags(4'b0000); {nEz, nEc, nEn, nEovr} = 4'b0000;
        {Yz, Yc, Yn, Yovr} = 4'b0000;
        Cx = 1'b0; nSE = 1'b0; {SIO0, SIOn, QIO0, QIOn} = 4'b0000;

        vecs[0] = '{{2'b11, 5'b00000, 6'o00}, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1010, 1'b1, 1'b0, {Z, 2'd0, Z, 2'd0}};
        vecs[1] = '{{2'b11, 5'b10110, 6'o45}, 4'b0000, 1'b0, 1'b0, 4'b0101, 4'b0101, 1'b1, 1'b1, {2'd1, Z, 2'd1, Z}};
        vecs[2] = '{{2'b00, 5'b01011, 6'o72}, 4'b0100, 1'b0, 1'b0, 4'b1000, 4'b0100, 1'b1, 1'b0, {Z, 2'd1, Z, 2'd1}};
        vecs[3] = '{{2'b01, 5'b11111, 6'o73}, 4'b0100, 1'b0, 1'b0, 4'b0110, 4'b0100, 1'b0, 1'b1, {2'd0, Z, 2'd1, Z}};
        vecs[4] = '{{2'b10, 5'b00000, 6'o14}, 4'b0000, 1'b1, 1'b1, 4'b1111, 4'b1010, 1'b1, 1'b1, {Z, Z, Z, Z}};
        vecs[5] = '{{2'b10, 5'b01110, 6'o56}, 4'b0000, 1'b0, 1'b0, 4'b0010, 4'b0101, 1'b0, 1'b0, {Z, 2'd1, Z, 2'd1}};
        vecs[6] = '{{2'b11, 5'b00101, 6'o43}, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0101, 1'b0, 1'b1, {Z, 2'd1, Z, 2'd1}};
        vecs[7] = '{{2'b11, 5'b10000, 6'o06}, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b1010, 1'b0, 1'b0, {2'd0, Z, 2'd0, Z}};
        vecs[8] = '{{2'b00, 5'b00000, 6'o70}, 4'b1000, 1'b0, 1'b0, 4'b0000, 4'b1000, 1'b1, 1'b0, {Z, 2'd0, Z, 2'd0}};
        vecs[9] = '{{2'b00, 5'b00000, 6'o31}, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b1010, 1'b0, 1'b0, {Z, Z, Z, Z}};

        // Reset, clear, Y tri-state
        #12;
        chk("rst_y", yNow(), 8'h00);
        reset = 1'b0;
        I = 13'(6'o03); nCEu = 1'b0; nCEm = 1'b0;
        tick();
        chk("clear_y", yNow(), 8'h00);
        nOEy = 1'b1; #1;
        chk("y_hiz", 8'((oYz === 1'bz) && (oYc === 1'bz) && (oYn === 1'bz) && (oYovr === 1'bz)), 8'h01);
        nOEy = 1'b0;

        // uSR set, then load with inverted carry
        nCEm = 1'b1; nCEu = 1'b0; I = 13'(6'o01);
        tick();
        chk("usr_set", yNow(), 8'h0F);
        I = 13'(6'o10); setFlags(4'b0100);
        tick();
        chk("usr_inv_c", yNow(), 8'h00);

        // MSR set with carry bit enable withheld
        nCEu = 1'b1; nCEm = 1'b0; nEc = 1'b1; I = 13'(6'o01);
        tick();
        nCEm = 1'b1; nEc = 1'b0; I = 13'(6'o41); #1;
        chk("msr_bitmask", yNow(), 8'h0B);

        // Sticky overflow on uSR ops 06/07
        nCEu = 1'b0; I = 13'(6'o06); setFlags(4'b0001);
        tick();
        I = 13'(6'o07); setFlags(4'b0000);
        tick();
        nCEu = 1'b1; I = 13'(6'o00); #1;
        chk("usr_sticky_ovr", yNow(), 8'h01);

        // MSR carry toggle (1011 -> 1111)
        nCEm = 1'b0; I = 13'(6'o06);
        tick();
        nCEm = 1'b1; I = 13'(6'o40); #1;
        chk("msr_toggle_c", yNow(), 8'h0F);

        // Swap uSR=1000 with MSR=0001
        nCEu = 1'b0; I = 13'(6'o04); setFlags(4'b1000);
        tick();
        nCEu = 1'b1; nCEm = 1'b0; I = 13'(6'o16); setFlags(4'b0001);
        tick();
        nCEu = 1'b0; I = 13'(6'o02); setFlags(4'b0000);
        tick();
        nCEu = 1'b1; nCEm = 1'b1; I = 13'(6'o00); #1;
        chk("swap_usr", yNow(), 8'h01);
        I = 13'(6'o40); #1;
        chk("swap_msr", yNow(), 8'h08);

        // CT on ALU flags and CT tri-state
        I = 13'(6'o72); setFlags(4'b0100); #1;
        chk("ct_c", 8'(CT), 8'h01);
        I = 13'(6'o73); #1;
        chk("ct_c_inv", 8'(CT), 8'h00);
        nOEct = 1'b1; #1;
        chk("ct_hiz", 8'(CT === 1'bz), 8'h01);
        nOEct = 1'b0;

        // Table: uSR=1010, MSR=0101
        nCEu = 1'b0; I = 13'(6'o04); setFlags(4'b1010);
        tick();
        nCEu = 1'b1; nCEm = 1'b0; I = 13'(6'o16); setFlags(4'b0101);
        tick();
        nCEm = 1'b1;
        for (int k = 0; k < 10; k++) begin
            I = vecs[k].i; setFlags(vecs[k].fl); Cx = vecs[k].cx; nSE = vecs[k].nse;
            {SIO0, SIOn, QIO0, QIOn} = vecs[k].pins;
            #2;
            shAct = {enc(oSIO0 === 1'bz, oSIO0), enc(oSIOn === 1'bz, oSIOn),
                     enc(oQIO0 === 1'bz, oQIO0), enc(oQIOn === 1'bz, oQIOn)};
            chk($sformatf("vec%0d_y", k), yNow(), {4'd0, vecs[k].expY});
            chk($sformatf("vec%0d_ct", k), 8'(CT), 8'(vecs[k].expCt));
            chk($sformatf("vec%0d_co", k), 8'(Co), 8'(vecs[k].expCo));
            chk($sformatf("vec%0d_shift", k), shAct, vecs[k].expSh);
        end

        // Asynchronous reset between edges
        @(posedge clk); #2;
        I = 13'(6'o00); nSE = 1'b0;
        reset = 1'b1; #1;
        chk("async_rst_usr", yNow(), 8'h00);
        I = 13'(6'o40); #1;
        chk("async_rst_msr", yNow(), 8'h00);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
